// File: rtl/pipe_pkg.sv
// Shared types and helpers for the in-order front end buffers.
// Packet typedefs let callers size pipe_flush_fifo with DWIDTH = $bits(<pkt>).
package pipe_pkg;

    function automatic int ptr_w(input int depth);
        return $clog2(depth);
    endfunction

    typedef struct packed {
        logic [31:0] instr;
        logic [8:0]  pc;
    } fetch_pkt_t;

    // 65-bit decode->rename bundle: fetch packet plus decoded register/op fields.
    typedef struct packed {
        logic [31:0] instr;
        logic [8:0]  pc;
        logic [5:0]  rd;
        logic [5:0]  rs1;
        logic [5:0]  rs2;
        logic [5:0]  op;
    } decode_pkt_t;

endpackage

// File: rtl/pipe_wrap_ptr.sv
// Increment-with-wrap pointer over DEPTH slots, with synchronous clear.
// Reset (active-low) and clear both return the pointer to slot 0.
module pipe_wrap_ptr
    import pipe_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clear,
    input  logic                    inc,
    output logic [ptr_w(DEPTH)-1:0] ptr
);

    localparam int PTR_W = ptr_w(DEPTH);
    localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

    always_ff @(posedge clk) begin
        if (!reset || clear) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= (ptr == LAST) ? '0 : ptr + PTR_W'(1);
        end
    end

endmodule

// File: rtl/pipe_flush_fifo.sv
// DEPTH-entry elastic buffer for fetch->decode->rename with branch-mispredict flush.
// Count, full and empty are registered so no input reaches o_ready/o_data combinationally.
module pipe_flush_fifo
    import pipe_pkg::*;
#(
    parameter  int DWIDTH = 41,
    parameter  int DEPTH  = 4,
    localparam int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic [DWIDTH-1:0] i_data,
    input  logic              i_valid,
    output logic              o_ready,
    output logic [DWIDTH-1:0] o_data,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [CNT_W-1:0]  o_count,
    output logic              o_full,
    output logic              o_empty
);

    localparam int PTR_W = ptr_w(DEPTH);

    logic [DWIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  ptr_diff;
    logic [CNT_W-1:0]  count_q;
    logic [CNT_W-1:0]  count_next;
    logic              full_q;
    logic              empty_q;
    logic              push;
    logic              pop;

    // Handshake: a transfer happens on a rising edge when valid & ready are both high
    // on that side and flush is low; while flush is high neither side transfers.
    assign push = i_valid & ~full_q & ~flush;
    assign pop  = ~empty_q & i_ready & ~flush;

    pipe_wrap_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
        .clk  (clk),
        .reset(reset),
        .clear(flush),
        .inc  (push),
        .ptr  (wr_ptr)
    );

    pipe_wrap_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
        .clk  (clk),
        .reset(reset),
        .clear(flush),
        .inc  (pop),
        .ptr  (rd_ptr)
    );

    always_ff @(posedge clk) begin
        if (reset && push) begin
            mem[wr_ptr] <= i_data;
        end
    end

    always_comb begin
        count_next = count_q;
        case ({push, pop})
            2'b10:   count_next = count_q + CNT_W'(1);
            2'b01:   count_next = count_q - CNT_W'(1);
            default: count_next = count_q;
        endcase
        if (flush) begin
            count_next = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            count_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            count_q <= count_next;
            full_q  <= (count_next == CNT_W'(DEPTH));
            empty_q <= (count_next == '0);
        end
    end

    assign o_ready = ~full_q;
    assign o_valid = ~empty_q;
    assign o_full  = full_q;
    assign o_empty = empty_q;
    assign o_count = count_q;
    assign o_data  = empty_q ? '0 : mem[rd_ptr];

    // Pointer distance aliases to 0 when full, so the full flag disambiguates.
    assign ptr_diff = wr_ptr - rd_ptr;

    always_ff @(posedge clk) begin
        if (reset) begin
            assert (!(push && full_q));
            assert (!(pop && empty_q));
            assert (count_q == (full_q ? CNT_W'(DEPTH) : CNT_W'(ptr_diff)));
        end
    end

endmodule

// File: tb/tb_pipe_flush_fifo.sv
// Bench for pipe_flush_fifo: directed scenarios plus random traffic,
// with an expected-data queue checked whenever the buffer hands a word downstream.
module tb_pipe_flush_fifo;

  localparam int DW    = 41;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk;
  logic          reset;
  logic          flush;
  logic [DW-1:0] i_data;
  logic          i_valid;
  logic          o_ready;
  logic [DW-1:0] o_data;
  logic          o_valid;
  logic          i_ready;
  logic [CW-1:0] o_count;
  logic          o_full;
  logic          o_empty;

  int checks;
  int failures;
  int model_count;
  bit sb_en;
  logic [DW-1:0] exp_q[$];

  pipe_flush_fifo #(.DWIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk    (clk),
    .reset  (reset),
    .flush  (flush),
    .i_data (i_data),
    .i_valid(i_valid),
    .o_ready(o_ready),
    .o_data (o_data),
    .o_valid(o_valid),
    .i_ready(i_ready),
    .o_count(o_count),
    .o_full (o_full),
    .o_empty(o_empty)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // drive one cycle: inputs applied just after an edge, held through the next edge
  task automatic cyc(input logic v, input logic [DW-1:0] d, input logic r, input logic f);
    i_valid = v;
    i_data  = d;
    i_ready = r;
    flush   = f;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    i_valid = 1'b0;
    i_data  = '0;
    i_ready = 1'b0;
    flush   = 1'b0;
  endtask

  // scoreboard: sampled mid-cycle, models the handshake about to happen on the next edge
  always @(negedge clk) begin
    if (sb_en) begin
      check("sb_count", 64'(o_count), 64'(model_count));
      check("sb_valid", 64'(o_valid), 64'(model_count != 0));
      check("sb_ready", 64'(o_ready), 64'(model_count != DEPTH));
      check("sb_full", 64'(o_full), 64'(model_count == DEPTH));
      check("sb_empty", 64'(o_empty), 64'(model_count == 0));
      if (model_count == 0) check("sb_data_zero", 64'(o_data), 64'd0);
      if (!reset || flush) begin
        exp_q.delete();
        model_count = 0;
      end else begin
        if (i_ready && model_count != 0) begin
          if (exp_q.size() == 0) begin
            check("sb_underflow", 64'(exp_q.size()), 64'd1);
          end else begin
            check("sb_data", 64'(o_data), 64'(exp_q.pop_front()));
          end
          model_count--;
        end
        if (i_valid && model_count + (i_ready && o_valid ? 1 : 0) != DEPTH) begin
          exp_q.push_back(i_data);
          model_count++;
        end
      end
    end
  end

  initial begin
    logic [63:0] rnd;
    checks   = 0;
    failures = 0;
    model_count = 0;
    sb_en    = 1'b0;
    reset    = 1'b0;
    idle_inputs();

    // reset held low for two edges
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_valid", 64'(o_valid), 64'd0);
    check("rst_ready", 64'(o_ready), 64'd1);
    check("rst_count", 64'(o_count), 64'd0);
    check("rst_data", 64'(o_data), 64'd0);
    check("rst_empty", 64'(o_empty), 64'd1);
    check("rst_full", 64'(o_full), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    sb_en = 1'b1;

    // single word held while downstream stalls
    cyc(1'b1, 41'h0DEADBEEF01, 1'b0, 1'b0);
    check("single_valid", 64'(o_valid), 64'd1);
    check("single_data", 64'(o_data), 64'h0DEADBEEF01);
    check("single_count", 64'(o_count), 64'd1);
    for (int k = 0; k < 5; k++) begin
      cyc(1'b0, '0, 1'b0, 1'b0);
      check("single_hold", 64'(o_data), 64'h0DEADBEEF01);
    end
    cyc(1'b0, '0, 1'b1, 1'b0);
    check("single_drained", 64'(o_count), 64'd0);

    // fill to DEPTH, then a dropped fifth push
    for (int k = 1; k <= 4; k++) cyc(1'b1, DW'(k), 1'b0, 1'b0);
    check("fill_full", 64'(o_full), 64'd1);
    check("fill_ready", 64'(o_ready), 64'd0);
    check("fill_count", 64'(o_count), 64'd4);
    cyc(1'b1, DW'(5), 1'b0, 1'b0);
    check("fill_drop_count", 64'(o_count), 64'd4);
    check("fill_head", 64'(o_data), 64'd1);

    // pop while full: ready stays low this cycle, rises next
    i_valid = 1'b0;
    i_ready = 1'b1;
    #2;
    check("fullpop_ready_low", 64'(o_ready), 64'd0);
    cyc(1'b0, '0, 1'b1, 1'b0);
    check("fullpop_ready_high", 64'(o_ready), 64'd1);
    check("fullpop_count", 64'(o_count), 64'd3);
    check("fullpop_head", 64'(o_data), 64'd2);
    repeat (3) cyc(1'b0, '0, 1'b1, 1'b0);
    check("fill_drained", 64'(o_count), 64'd0);

    // streaming through several pointer wraps
    for (int k = 0; k < 20; k++) begin
      cyc(1'b1, DW'(100 + k), 1'b1, 1'b0);
      check("stream_count", 64'(o_count), 64'd1);
      check("stream_data", 64'(o_data), 64'(100 + k));
    end
    cyc(1'b0, '0, 1'b1, 1'b0);
    check("stream_drained", 64'(o_count), 64'd0);

    // flush at count 3 with simultaneous push and pop
    cyc(1'b1, DW'('hA1), 1'b0, 1'b0);
    cyc(1'b1, DW'('hA2), 1'b0, 1'b0);
    cyc(1'b1, DW'('hA3), 1'b0, 1'b0);
    check("preflush_count", 64'(o_count), 64'd3);
    cyc(1'b1, DW'('hFF), 1'b1, 1'b1);
    check("flush_count", 64'(o_count), 64'd0);
    check("flush_valid", 64'(o_valid), 64'd0);
    cyc(1'b1, DW'('hB1), 1'b0, 1'b0);
    check("postflush_data", 64'(o_data), 64'hB1);
    check("postflush_count", 64'(o_count), 64'd1);

    // reset together with flush mid-stream, then full-rate acceptance
    cyc(1'b1, DW'('hB2), 1'b0, 1'b0);
    reset = 1'b0;
    cyc(1'b1, DW'('hB3), 1'b1, 1'b1);
    reset = 1'b1;
    check("midreset_count", 64'(o_count), 64'd0);
    check("midreset_ready", 64'(o_ready), 64'd1);
    cyc(1'b1, DW'('hC1), 1'b0, 1'b0);
    cyc(1'b1, DW'('hC2), 1'b0, 1'b0);
    check("midreset_rate", 64'(o_count), 64'd2);
    check("midreset_head", 64'(o_data), 64'hC1);
    repeat (2) cyc(1'b0, '0, 1'b1, 1'b0);

    // random traffic, checked by the scoreboard
    for (int k = 0; k < 10000; k++) begin
      rnd = {$urandom, $urandom};
      cyc(1'($urandom_range(0, 1)), rnd[DW-1:0], 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 31) == 0));
    end

    repeat (DEPTH + 2) cyc(1'b0, '0, 1'b1, 1'b0);
    check("final_queue_empty", 64'(exp_q.size()), 64'd0);
    check("final_count", 64'(o_count), 64'd0);
    sb_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
